data_cache: RTL

Write-back, write-allocate, direct-mapped data cache between the RV32IM pipeline's MEM stage and the 128-bit block data memory. It accepts 32-bit word reads and writes from the CPU and stalls the pipeline through BUSYWAIT on misses. As bus initiator it issues block reads and writebacks on the memory READ/WRITE/BUSYWAIT interface, where the memory serves one 16-byte block per request.

---
 rtl/dcache_pkg.sv | 26 ++
 rtl/dcache_array.sv | 57 +++++
 rtl/data_cache.sv | 110 +++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and field positions for the direct-mapped write-back data cache.
// The block memory is addressed in 16-byte blocks; the CPU side in 32-bit words.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_t;

  localparam int BLOCK_BITS    = 128;
  localparam int WORD_BITS     = 32;
  localparam int MEM_ADDR_BITS = 28;
  localparam int ADDR_BITS     = 32;
  localparam int OFFSET_LSB    = 2;
  localparam int OFFSET_BITS   = 2;
  localparam int INDEX_LSB     = 4;

  function automatic logic [WORD_BITS-1:0] select_word(
    input logic [BLOCK_BITS-1:0]  blk,
    input logic [OFFSET_BITS-1:0] off
  );
    return blk[off*WORD_BITS +: WORD_BITS];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: valid/dirty bits (async-cleared) plus tag and data arrays (not reset).
// Reads are combinational by index; word writes and block fills land at the clock edge.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = 8,
  parameter int IDX      = $clog2(NUM_SETS),
  parameter int TAG_BITS = MEM_ADDR_BITS - IDX
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IDX-1:0]         index,
  output logic                   line_valid,
  output logic                   line_dirty,
  output logic [TAG_BITS-1:0]    line_tag,
  output logic [BLOCK_BITS-1:0]  line_data,
  input  logic                   word_we,
  input  logic [OFFSET_BITS-1:0] word_offset,
  input  logic [WORD_BITS-1:0]   word_data,
  input  logic                   fill_we,
  input  logic [TAG_BITS-1:0]    fill_tag,
  input  logic [BLOCK_BITS-1:0]  fill_data
);

  logic [NUM_SETS-1:0]   valid;
  logic [NUM_SETS-1:0]   dirty;
  logic [TAG_BITS-1:0]   tag_mem  [NUM_SETS];
  logic [BLOCK_BITS-1:0] data_mem [NUM_SETS];

  assign line_valid = valid[index];
  assign line_dirty = dirty[index];
  assign line_tag   = tag_mem[index];
  assign line_data  = data_mem[index];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_we) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (word_we) begin
      dirty[index] <= 1'b1;
    end
  end

  // A fill replaces the whole line, so it takes priority over a word write.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[index]  <= fill_tag;
      data_mem[index] <= fill_data;
    end else if (word_we) begin
      data_mem[index][word_offset*WORD_BITS +: WORD_BITS] <= word_data;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Write-back, write-allocate, direct-mapped data cache between the MEM stage and
// 128-bit block memory. Hits complete with no stall; misses stall via BUSYWAIT.
module data_cache
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = 8
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     READ,
  input  logic                     WRITE,
  input  logic [ADDR_BITS-1:0]     ADDRESS,
  input  logic [WORD_BITS-1:0]     WRITEDATA,
  output logic [WORD_BITS-1:0]     READDATA,
  output logic                     BUSYWAIT,
  output logic                     MEM_READ,
  output logic                     MEM_WRITE,
  output logic [MEM_ADDR_BITS-1:0] MEM_ADDRESS,
  output logic [BLOCK_BITS-1:0]    MEM_WRITEDATA,
  input  logic [BLOCK_BITS-1:0]    MEM_READDATA,
  input  logic                     MEM_BUSYWAIT
);

  localparam int IDX      = $clog2(NUM_SETS);
  localparam int TAG_BITS = MEM_ADDR_BITS - IDX;

  state_t state, next_state;

  logic [IDX-1:0]         index;
  logic [TAG_BITS-1:0]    addr_tag;
  logic [OFFSET_BITS-1:0] offset;
  logic                   line_valid, line_dirty;
  logic [TAG_BITS-1:0]    line_tag;
  logic [BLOCK_BITS-1:0]  line_data;
  logic                   req, hit, word_we, fill_we;
  logic                   unused_byte_bits;

  assign index            = ADDRESS[INDEX_LSB +: IDX];
  assign addr_tag         = ADDRESS[ADDR_BITS-1 : INDEX_LSB+IDX];
  assign offset           = ADDRESS[OFFSET_LSB +: OFFSET_BITS];
  assign unused_byte_bits = ^ADDRESS[OFFSET_LSB-1:0];

  // Exactly one of READ/WRITE makes a request; both high is ignored outright.
  assign req      = READ ^ WRITE;
  assign hit      = (state == IDLE) && line_valid && (line_tag == addr_tag);
  assign READDATA = select_word(line_data, offset);

  dcache_array #(
    .NUM_SETS(NUM_SETS),
    .IDX     (IDX),
    .TAG_BITS(TAG_BITS)
  ) u_array (
    .clk        (CLK),
    .reset      (RESET),
    .index      (index),
    .line_valid (line_valid),
    .line_dirty (line_dirty),
    .line_tag   (line_tag),
    .line_data  (line_data),
    .word_we    (word_we),
    .word_offset(offset),
    .word_data  (WRITEDATA),
    .fill_we    (fill_we),
    .fill_tag   (addr_tag),
    .fill_data  (MEM_READDATA)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // Memory handshake: a request is held while MEM_BUSYWAIT is high and is
  // considered served at the first posedge that samples MEM_BUSYWAIT low.
  always_comb begin
    next_state    = state;
    BUSYWAIT      = req && !hit;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    word_we       = 1'b0;
    fill_we       = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (hit)                          word_we    = WRITE;
          else if (line_valid && line_dirty) next_state = WRITEBACK;
          else                               next_state = FETCH;
        end
      end
      WRITEBACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {line_tag, index};
        MEM_WRITEDATA = line_data;
        if (!MEM_BUSYWAIT) next_state = FETCH;
      end
      FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = ADDRESS[ADDR_BITS-1:INDEX_LSB];
        if (!MEM_BUSYWAIT) begin
          fill_we    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
